bip_run_controller: RTL and testbench
=====================================

Name: bip_run_controller

Overview:
Sequencer that owns the BIP processor's program memory write port, CPU reset and enable, and the data-memory read path for debug. It executes host commands in three phases. LOAD streams a program into program memory. RUN releases the CPU, counts cycles and stops on the HALT opcode. DUMP reads data memory words out over a valid/ready stream. It sits in the BIP top level between the host link (UART/debug bridge) and the CPU/memory instances; the data-memory address/read mux selects this block whenever o_dm_sel=1.

Parameters:
NB_BITS, 16, instruction/data word width
INS_MEM_DEPTH, 2048, program memory words; AW_I = clogb2(INS_MEM_DEPTH-1)
DATA_MEM_DEPTH, 2048, data memory words; AW_D = clogb2(DATA_MEM_DEPTH-1)
NB_OPCODE, 5, opcode field width = instruction[NB_BITS-1 -: NB_OPCODE]
HALT_OPCODE, 5'b00000, opcode that stops RUN
NB_CYC, 32, cycle counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_cmd_valid  in  1  command strobe
i_cmd  in  2  01 LOAD, 10 RUN, 11 DUMP, 00 ignored
o_cmd_ready  out  1  high only in IDLE
i_abort  in  1  abort RUN/LOAD/DUMP, return to IDLE
i_dump_len  in  AW_D+1  words to dump (sampled at DUMP accept)
i_ld_valid  in  1  program word valid
i_ld_data  in  NB_BITS  program word
i_ld_last  in  1  final word of program
o_ld_ready  out  1  high in LOAD
o_pm_wr  out  1  program memory write enable
o_pm_addr  out  AW_I  program memory write address
o_pm_data  out  NB_BITS  program memory write data
i_instruction  in  NB_BITS  program memory output (CPU fetch)
o_cpu_rst  out  1  CPU reset
o_cpu_en  out  1  CPU clock enable
o_dm_sel  out  1  1 = controller drives data memory address/read
o_dm_rd  out  1  data memory read strobe
o_dm_addr  out  AW_D  data memory read address
i_dm_data  in  NB_BITS  data memory read data, 1-cycle latency
o_dump_valid  out  1  dump word valid
o_dump_data  out  NB_BITS  dump word
o_dump_last  out  1  last dump word
i_dump_ready  in  1  dump sink ready
o_cycles  out  NB_CYC  cycles executed in last RUN
o_timeout  out  1  counter saturated in last RUN
o_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, RUN_INIT, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- Reset (async):
  - state=IDLE; all addresses, counters, o_cycles, o_timeout, o_dump_data cleared.
  - o_cpu_rst = i_rst OR state in {LOAD, RUN_INIT}.
  - o_cpu_en=0, o_dm_sel=0 while in reset.
- IDLE: a command is accepted when i_cmd_valid & o_cmd_ready. Code 00 stays in IDLE. The CPU is frozen (en=0) but not reset, so its state survives for DUMP.
- LOAD:
  - A word is accepted on i_ld_valid & o_ld_ready. The same cycle, o_pm_wr=1, o_pm_addr=ld_addr, o_pm_data=i_ld_data (combinational pass); ld_addr increments.
  - Exit to IDLE after the word flagged i_ld_last, or after the word written at INS_MEM_DEPTH-1. There is no wrap; further words are not accepted.
  - ld_addr clears on LOAD entry.
- RUN_INIT: one cycle, o_cpu_rst=1; o_cycles and o_timeout are cleared. Next state is RUN.
- RUN:
  - halt = opcode(i_instruction)==HALT_OPCODE.
  - o_cpu_en = ~halt & ~i_abort, combinational.
  - o_cycles increments every cycle o_cpu_en=1.
  - On halt or i_abort, go to IDLE next edge.
  - On o_cycles reaching all-ones: set o_timeout, go to IDLE; the counter holds at all-ones.
- DUMP:
  - On accept, latch len=i_dump_len and clear dm_addr. If len==0, return straight to IDLE.
  - o_dm_sel=1 in all DUMP states.
  - DUMP_RD: o_dm_rd=1 at dm_addr, then go to DUMP_WAIT.
  - DUMP_WAIT: register i_dm_data into o_dump_data, then go to DUMP_OUT.
  - DUMP_OUT: o_dump_valid=1 and o_dump_last=(dm_addr==len-1); data is held stable until i_dump_ready.
  - On handshake: if last, go to IDLE; else dm_addr+1 and go to DUMP_RD. Throughput is one word per 3 cycles minimum.
  - len > DATA_MEM_DEPTH is clamped to DATA_MEM_DEPTH.
- i_abort has priority over every other transition. In any non-IDLE state it forces IDLE next edge and drops valid/ready/wr. A partially loaded program stays in memory.
- i_cmd_valid outside IDLE is ignored (ready=0); commands are not queued.
- The dump and load streams may both be active only in their own state; handshakes in other states have no effect.

Decomposition:
- Package bip_pkg: command codes (CMD_LOAD/RUN/DUMP), state encoding typedef, HALT_OPCODE default, clogb2 function shared with the BIP top.
- Sub-module bip_cycle_counter: saturating NB_CYC counter with clear, enable and saturation flag.

Test Plan:
- LOAD of 3 words 0x1111/0x2222/0x3333, last on third -> o_pm_wr at addr 0,1,2 with matching data; IDLE after; o_cpu_rst high throughout.
- RUN, program memory outputs non-HALT for 10 cycles then opcode 00000 -> o_cycles=10, o_timeout=0, o_cpu_en low on the HALT cycle, IDLE next edge.
- DUMP len=4, memory returns addr*3, i_dump_ready toggling every other cycle -> words 0,3,6,9 in order, data stable while stalled, o_dump_last only on 9.
- DUMP len=0 -> no o_dm_rd, no o_dump_valid, back to IDLE in one cycle.
- LOAD without i_ld_last, INS_MEM_DEPTH=4 -> 4 writes (addr 0..3), fifth word not accepted, IDLE.
- i_abort in RUN, and async i_rst mid DUMP_OUT -> IDLE next edge / immediately, o_dump_valid=0, o_cpu_en=0, o_dm_sel=0.

Source files
------------

// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP run controller and the BIP top level:
// host command codes, controller state encoding, default HALT opcode and the
// clogb2 helper used to size address buses from memory depths.
// -----------------------------------------------------------------------------
package bip_pkg;

  // Host command codes (2'b00 is a no-op)
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_RUN_INIT  = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_DUMP_RD   = 3'd4;
  localparam state_t ST_DUMP_WAIT = 3'd5;
  localparam state_t ST_DUMP_OUT  = 3'd6;

  localparam logic [4:0] HALT_OPCODE_DEFAULT = 5'b00000;

  // Number of bits needed to represent 'value' (clogb2(DEPTH-1) = address width)
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bip_cycle_counter.sv
// -----------------------------------------------------------------------------
// bip_cycle_counter
// Saturating cycle counter. Counts while i_en is high, holds at all-ones.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clr          synchronous clear (wins over i_en)
//   i_en           count enable
//   o_count        current count
//   o_sat          count is all-ones
// -----------------------------------------------------------------------------
module bip_cycle_counter #(
  parameter int NB_CYC = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [NB_CYC-1:0] o_count,
  output logic              o_sat
);

  logic [NB_CYC-1:0] r_count;
  logic              w_sat;

  assign w_sat = &r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_sat) begin
      r_count <= r_count + NB_CYC'(1);
    end
  end

  assign o_count = r_count;
  assign o_sat   = w_sat;

endmodule

// File: rtl/bip_run_controller.sv
// -----------------------------------------------------------------------------
// bip_run_controller
// Sequencer for the BIP processor: loads programs into program memory, runs
// the CPU until the HALT opcode (counting cycles), and dumps data memory over
// a valid/ready stream.
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_cmd_valid/i_cmd/o_cmd_ready   host command (01 LOAD, 10 RUN, 11 DUMP)
//   i_abort                         return to IDLE from any busy state
//   i_dump_len                      number of words to dump
//   i_ld_valid/i_ld_data/i_ld_last/o_ld_ready   program load stream
//   o_pm_wr/o_pm_addr/o_pm_data     program memory write port
//   i_instruction                   program memory fetch output (HALT detect)
//   o_cpu_rst/o_cpu_en              CPU reset and clock enable
//   o_dm_sel/o_dm_rd/o_dm_addr      data memory read port (when o_dm_sel=1)
//   i_dm_data                       data memory read data (1-cycle latency)
//   o_dump_valid/o_dump_data/o_dump_last/i_dump_ready   dump stream
//   o_cycles/o_timeout              cycle count / saturation of last RUN
//   o_busy                          controller not in IDLE
// -----------------------------------------------------------------------------
module bip_run_controller
  import bip_pkg::*;
#(
  parameter int               NB_BITS        = 16,
  parameter int               INS_MEM_DEPTH  = 2048,
  parameter int               DATA_MEM_DEPTH = 2048,
  parameter int               NB_OPCODE      = 5,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = NB_OPCODE'(HALT_OPCODE_DEFAULT),
  parameter int               NB_CYC         = 32,
  localparam int              AW_I           = clogb2(INS_MEM_DEPTH-1),
  localparam int              AW_D           = clogb2(DATA_MEM_DEPTH-1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_abort,
  input  logic [AW_D:0]      i_dump_len,
  input  logic               i_ld_valid,
  input  logic [NB_BITS-1:0] i_ld_data,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  output logic               o_pm_wr,
  output logic [AW_I-1:0]    o_pm_addr,
  output logic [NB_BITS-1:0] o_pm_data,
  input  logic [NB_BITS-1:0] i_instruction,
  output logic               o_cpu_rst,
  output logic               o_cpu_en,
  output logic               o_dm_sel,
  output logic               o_dm_rd,
  output logic [AW_D-1:0]    o_dm_addr,
  input  logic [NB_BITS-1:0] i_dm_data,
  output logic               o_dump_valid,
  output logic [NB_BITS-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic [NB_CYC-1:0]  o_cycles,
  output logic               o_timeout,
  output logic               o_busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW_I-1:0]     r_ld_addr;
  logic [AW_D-1:0]     r_dm_addr;
  logic [AW_D:0]       r_len;
  logic [NB_BITS-1:0]  r_dump_data;
  logic                r_timeout;

  logic                w_halt;
  logic                w_in_run;
  logic                w_cpu_en;
  logic                w_cmd_acc;
  logic                w_ld_acc;
  logic                w_ld_end;
  logic [AW_D:0]       w_len_clamped;
  logic                w_dump_vld;
  logic                w_dump_last;
  logic                w_dump_hs;
  logic                w_sat;
  logic [NB_CYC-1:0]   w_cycles;
  logic                w_unused_ins;

  // Only the opcode field of the fetched instruction matters here
  assign w_unused_ins = ^i_instruction[NB_BITS-NB_OPCODE-1:0];

  assign w_halt    = (i_instruction[NB_BITS-1 -: NB_OPCODE] == HALT_OPCODE);
  assign w_in_run  = (r_state == ST_RUN);
  assign w_cpu_en  = w_in_run & ~w_halt & ~i_abort;
  assign w_cmd_acc = (r_state == ST_IDLE) & i_cmd_valid;

  // Program load: the last address ends LOAD even without i_ld_last (no wrap)
  assign w_ld_acc = (r_state == ST_LOAD) & ~i_abort & i_ld_valid;
  assign w_ld_end = w_ld_acc & (i_ld_last | (r_ld_addr == AW_I'(INS_MEM_DEPTH-1)));

  assign w_len_clamped = (i_dump_len > (AW_D+1)'(DATA_MEM_DEPTH)) ?
                         (AW_D+1)'(DATA_MEM_DEPTH) : i_dump_len;

  assign w_dump_vld  = (r_state == ST_DUMP_OUT) & ~i_abort;
  assign w_dump_last = ({1'b0, r_dm_addr} == (r_len - (AW_D+1)'(1)));
  assign w_dump_hs   = w_dump_vld & i_dump_ready;

  bip_cycle_counter #(
    .NB_CYC (NB_CYC)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (r_state == ST_RUN_INIT),
    .i_en    (w_cpu_en),
    .o_count (w_cycles),
    .o_sat   (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          case (i_cmd)
            CMD_LOAD: w_state_nxt = ST_LOAD;
            CMD_RUN:  w_state_nxt = ST_RUN_INIT;
            CMD_DUMP: w_state_nxt = (i_dump_len == '0) ? ST_IDLE : ST_DUMP_RD;
            default:  w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_LOAD:      if (w_ld_end) w_state_nxt = ST_IDLE;
      ST_RUN_INIT:  w_state_nxt = ST_RUN;
      ST_RUN:       if (w_halt || w_sat) w_state_nxt = ST_IDLE;
      ST_DUMP_RD:   w_state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: w_state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT:  if (w_dump_hs) w_state_nxt = w_dump_last ? ST_IDLE : ST_DUMP_RD;
      default:      w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides every busy-state transition; IDLE keeps its handshake
    if (i_abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ld_addr   <= '0;
      r_dm_addr   <= '0;
      r_len       <= '0;
      r_dump_data <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_cmd_acc && (i_cmd == CMD_LOAD)) begin
        r_ld_addr <= '0;
      end else if (w_ld_acc) begin
        r_ld_addr <= r_ld_addr + AW_I'(1);
      end

      if (w_cmd_acc && (i_cmd == CMD_DUMP)) begin
        r_len     <= w_len_clamped;
        r_dm_addr <= '0;
      end else if (w_dump_hs && !w_dump_last) begin
        r_dm_addr <= r_dm_addr + AW_D'(1);
      end

      // Read data arrives one cycle after the DUMP_RD strobe
      if (r_state == ST_DUMP_WAIT) r_dump_data <= i_dm_data;

      if (r_state == ST_RUN_INIT) begin
        r_timeout <= 1'b0;
      end else if (w_in_run && w_sat && !i_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_cmd_ready  = (r_state == ST_IDLE);
  assign o_ld_ready   = (r_state == ST_LOAD) & ~i_abort;
  assign o_pm_wr      = w_ld_acc;
  assign o_pm_addr    = r_ld_addr;
  assign o_pm_data    = i_ld_data;
  assign o_cpu_rst    = i_rst | (r_state == ST_LOAD) | (r_state == ST_RUN_INIT);
  assign o_cpu_en     = w_cpu_en;
  assign o_dm_sel     = (r_state == ST_DUMP_RD) | (r_state == ST_DUMP_WAIT) |
                        (r_state == ST_DUMP_OUT);
  assign o_dm_rd      = (r_state == ST_DUMP_RD) & ~i_abort;
  assign o_dm_addr    = r_dm_addr;
  assign o_dump_valid = w_dump_vld;
  assign o_dump_data  = r_dump_data;
  assign o_dump_last  = w_dump_vld & w_dump_last;
  assign o_cycles     = w_cycles;
  assign o_timeout    = r_timeout;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bip_run_controller.sv
// -----------------------------------------------------------------------------
// tb_bip_run_controller
// Directed bench with a scoreboard: expected program-memory writes and dump
// words are queued by the stimulus; a negedge monitor pops and compares them
// whenever the DUT writes program memory or completes a dump handshake.
// -----------------------------------------------------------------------------
module tb_bip_run_controller;
  import bip_pkg::*;

  localparam int NB_BITS = 16;
  localparam int IMD     = 4;
  localparam int DMD     = 8;
  localparam int NB_CYC  = 32;
  localparam int AW_I    = 2;
  localparam int AW_D    = 3;

  logic               i_clk;
  logic               i_rst;
  logic               i_cmd_valid;
  logic [1:0]         i_cmd;
  logic               o_cmd_ready;
  logic               i_abort;
  logic [AW_D:0]      i_dump_len;
  logic               i_ld_valid;
  logic [NB_BITS-1:0] i_ld_data;
  logic               i_ld_last;
  logic               o_ld_ready;
  logic               o_pm_wr;
  logic [AW_I-1:0]    o_pm_addr;
  logic [NB_BITS-1:0] o_pm_data;
  logic [NB_BITS-1:0] i_instruction;
  logic               o_cpu_rst;
  logic               o_cpu_en;
  logic               o_dm_sel;
  logic               o_dm_rd;
  logic [AW_D-1:0]    o_dm_addr;
  logic [NB_BITS-1:0] i_dm_data;
  logic               o_dump_valid;
  logic [NB_BITS-1:0] o_dump_data;
  logic               o_dump_last;
  logic               i_dump_ready;
  logic [NB_CYC-1:0]  o_cycles;
  logic               o_timeout;
  logic               o_busy;

  bip_run_controller #(
    .NB_BITS        (NB_BITS),
    .INS_MEM_DEPTH  (IMD),
    .DATA_MEM_DEPTH (DMD),
    .NB_CYC         (NB_CYC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd         (i_cmd),
    .o_cmd_ready   (o_cmd_ready),
    .i_abort       (i_abort),
    .i_dump_len    (i_dump_len),
    .i_ld_valid    (i_ld_valid),
    .i_ld_data     (i_ld_data),
    .i_ld_last     (i_ld_last),
    .o_ld_ready    (o_ld_ready),
    .o_pm_wr       (o_pm_wr),
    .o_pm_addr     (o_pm_addr),
    .o_pm_data     (o_pm_data),
    .i_instruction (i_instruction),
    .o_cpu_rst     (o_cpu_rst),
    .o_cpu_en      (o_cpu_en),
    .o_dm_sel      (o_dm_sel),
    .o_dm_rd       (o_dm_rd),
    .o_dm_addr     (o_dm_addr),
    .i_dm_data     (i_dm_data),
    .o_dump_valid  (o_dump_valid),
    .o_dump_data   (o_dump_data),
    .o_dump_last   (o_dump_last),
    .i_dump_ready  (i_dump_ready),
    .o_cycles      (o_cycles),
    .o_timeout     (o_timeout),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Data memory model: word at address a holds a*3, one-cycle read latency
  always @(posedge i_clk) begin
    if (o_dm_rd) i_dm_data <= 16'(o_dm_addr) * 16'd3;
  end

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int dv_cnt = 0;

  logic [31:0] pm_q[$];    // {addr, data}
  logic [16:0] dump_q[$];  // {last, data}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic [31:0]        pm_e;
  logic [16:0]        dump_e;
  logic               stall_hold = 1'b0;
  logic [NB_BITS-1:0] held_data;

  always @(negedge i_clk) begin
    if (o_dm_rd) rd_cnt++;
    if (o_dump_valid) dv_cnt++;

    if (o_pm_wr) begin
      if (pm_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pm_wr_unexpected: got addr %0h data %0h expected no write", o_pm_addr, o_pm_data);
      end else begin
        pm_e = pm_q.pop_front();
        chk("pm_addr", 64'(o_pm_addr), 64'(pm_e[31:16]));
        chk("pm_data", 64'(o_pm_data), 64'(pm_e[15:0]));
        chk("cpu_rst_during_load", 64'(o_cpu_rst), 64'd1);
      end
    end

    if (o_dump_valid) begin
      if (stall_hold) chk("dump_data_stable", 64'(o_dump_data), 64'(held_data));
      if (i_dump_ready) begin
        stall_hold = 1'b0;
        if (dump_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dump_unexpected: got data %0h expected no word", o_dump_data);
        end else begin
          dump_e = dump_q.pop_front();
          chk("dump_data", 64'(o_dump_data), 64'(dump_e[15:0]));
          chk("dump_last", 64'(o_dump_last), 64'(dump_e[16]));
        end
      end else begin
        stall_hold = 1'b1;
        held_data  = o_dump_data;
      end
    end else begin
      stall_hold = 1'b0;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    i_cmd       = 2'b00;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n;
    n = 0;
    while (o_busy && n < maxc) begin
      step();
      n++;
    end
    chk(nm, 64'(o_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    int v0;

    i_rst         = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd         = 2'b00;
    i_abort       = 1'b0;
    i_dump_len    = '0;
    i_ld_valid    = 1'b0;
    i_ld_data     = '0;
    i_ld_last     = 1'b0;
    i_instruction = 16'h0800;
    i_dump_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_cpu_rst", 64'(o_cpu_rst), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_cycles", 64'(o_cycles), 64'd0);
    chk("rst_dm_sel", 64'(o_dm_sel), 64'd0);
    i_rst = 1'b0;
    step();
    chk("idle_cmd_ready", 64'(o_cmd_ready), 64'd1);
    chk("idle_cpu_rst", 64'(o_cpu_rst), 64'd0);
    chk("idle_cpu_en", 64'(o_cpu_en), 64'd0);

    // LOAD three words, last on third
    for (int i = 0; i < 3; i++) pm_q.push_back({16'(i), 16'h1111 * 16'(i + 1)});
    send_cmd(CMD_LOAD);
    chk("load_ld_ready", 64'(o_ld_ready), 64'd1);
    chk("load_cmd_ready", 64'(o_cmd_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = 16'h1111 * 16'(i + 1);
      i_ld_last  = (i == 2);
      step();
    end
    i_ld_valid = 1'b0;
    i_ld_last  = 1'b0;
    chk("load3_idle", 64'(o_busy), 64'd0);
    chk("load3_ld_ready", 64'(o_ld_ready), 64'd0);
    chk("load3_all_written", 64'(pm_q.size()), 64'd0);

    // RUN: 10 non-HALT cycles then HALT
    i_instruction = 16'h0800;
    send_cmd(CMD_RUN);
    chk("run_init_cpu_rst", 64'(o_cpu_rst), 64'd1);
    chk("run_init_cpu_en", 64'(o_cpu_en), 64'd0);
    step();
    chk("run_cpu_en", 64'(o_cpu_en), 64'd1);
    chk("run_cpu_rst", 64'(o_cpu_rst), 64'd0);
    repeat (10) step();
    i_instruction = 16'h0123;
    #1;
    chk("halt_cpu_en", 64'(o_cpu_en), 64'd0);
    chk("halt_busy", 64'(o_busy), 64'd1);
    step();
    chk("halt_idle", 64'(o_busy), 64'd0);
    chk("halt_cycles", 64'(o_cycles), 64'd10);
    chk("halt_timeout", 64'(o_timeout), 64'd0);

    // DUMP len=4 with toggling ready
    for (int i = 0; i < 4; i++) dump_q.push_back({(i == 3), 16'(i * 3)});
    i_dump_len   = 4'd4;
    i_dump_ready = 1'b0;
    send_cmd(CMD_DUMP);
    chk("dump_dm_sel", 64'(o_dm_sel), 64'd1);
    n = 0;
    while (o_busy && n < 60) begin
      step();
      i_dump_ready = ~i_dump_ready;
      n++;
    end
    i_dump_ready = 1'b0;
    chk("dump4_idle", 64'(o_busy), 64'd0);
    chk("dump4_all_words", 64'(dump_q.size()), 64'd0);
    chk("dump4_dm_sel_off", 64'(o_dm_sel), 64'd0);

    // DUMP len=0
    r0 = rd_cnt;
    v0 = dv_cnt;
    i_dump_len = 4'd0;
    send_cmd(CMD_DUMP);
    chk("dump0_idle", 64'(o_busy), 64'd0);
    step();
    step();
    chk("dump0_no_rd", 64'(rd_cnt), 64'(r0));
    chk("dump0_no_valid", 64'(dv_cnt), 64'(v0));

    // LOAD without last: stops at the final address, fifth word refused
    for (int i = 0; i < 4; i++) pm_q.push_back({16'(i), 16'hA000 + 16'(i)});
    send_cmd(CMD_LOAD);
    for (int i = 0; i < 5; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = 16'hA000 + 16'(i);
      i_ld_last  = 1'b0;
      if (i == 4) chk("load_full_ready", 64'(o_ld_ready), 64'd0);
      step();
    end
    i_ld_valid = 1'b0;
    chk("load_full_idle", 64'(o_busy), 64'd0);
    chk("load_full_written", 64'(pm_q.size()), 64'd0);

    // Abort during RUN
    i_instruction = 16'h0800;
    send_cmd(CMD_RUN);
    step();
    step();
    step();
    i_abort = 1'b1;
    #1;
    chk("abort_cpu_en", 64'(o_cpu_en), 64'd0);
    chk("abort_busy_before", 64'(o_busy), 64'd1);
    step();
    i_abort = 1'b0;
    chk("abort_idle", 64'(o_busy), 64'd0);
    chk("abort_cycles", 64'(o_cycles), 64'd2);

    // DUMP length above depth is clamped
    for (int i = 0; i < 8; i++) dump_q.push_back({(i == 7), 16'(i * 3)});
    i_dump_len   = 4'd9;
    i_dump_ready = 1'b1;
    send_cmd(CMD_DUMP);
    wait_idle("clamp_idle", 100);
    chk("clamp_all_words", 64'(dump_q.size()), 64'd0);
    i_dump_ready = 1'b0;

    // Asynchronous reset in DUMP_OUT
    i_dump_len = 4'd4;
    send_cmd(CMD_DUMP);
    n = 0;
    while (!o_dump_valid && n < 20) begin
      step();
      n++;
    end
    chk("reach_dump_out", 64'(o_dump_valid), 64'd1);
    #3;
    i_rst = 1'b1;
    #1;
    chk("arst_dump_valid", 64'(o_dump_valid), 64'd0);
    chk("arst_dm_sel", 64'(o_dm_sel), 64'd0);
    chk("arst_cpu_en", 64'(o_cpu_en), 64'd0);
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_cycles", 64'(o_cycles), 64'd0);
    chk("arst_cpu_rst", 64'(o_cpu_rst), 64'd1);
    step();
    i_rst = 1'b0;
    step();
    chk("post_rst_cmd_ready", 64'(o_cmd_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
